// File: rtl/mips16_pkg.sv
// Shared MIPS16 data-memory types: bus widths, arbiter FSM encoding, requester ids.
// Also holds the address legality rule used when a request is granted.
package mips16_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

  // Word-aligned and inside the populated part of data memory.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] addr, input int unsigned words);
    return (addr[0] == 1'b0) && (32'(addr[ADDR_W-1:1]) < words);
  endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational 2-way winner select; round-robin when DMEM_ARB_RR_EN is defined, else fixed r0 priority.
// Zero latency; a losing requester is simply not granted and keeps waiting.
module dmem_arb_pick
  import mips16_pkg::*;
(
  input  logic r0_req,
  input  logic r1_req,
`ifdef DMEM_ARB_RR_EN
  input  logic last_grant,
`endif
  output logic grant_vld,
  output logic grant_id
);

  always_comb begin
    grant_vld = r0_req | r1_req;
    grant_id  = REQ_CPU;
`ifdef DMEM_ARB_RR_EN
    // On a tie the requester that did not win last time goes first.
    if (r0_req && r1_req) begin
      grant_id = ~last_grant;
    end else if (r1_req) begin
      grant_id = REQ_DMA;
    end
`else
    if (!r0_req && r1_req) begin
      grant_id = REQ_DMA;
    end
`endif
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter (IDLE->ACCESS->RESP), done two cycles after a request is seen in IDLE.
// Requesters hold req until done; optional round-robin tie-break via DMEM_ARB_RR_EN.
module dmem_arbiter
  import mips16_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_done,
  output logic              r0_err,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_done,
  output logic              r1_err,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [ADDR_W-1:0] mem_access_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_en,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy
);

  arb_state_t        state;
  arb_state_t        state_nxt;
  logic              grant_vld;
  logic              grant_id;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              lat_id;
  logic              lat_we;
  logic              lat_bad;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
`ifdef DMEM_ARB_RR_EN
  logic              last_grant;
`endif

  dmem_arb_pick u_pick (
    .r0_req     (r0_req),
    .r1_req     (r1_req),
`ifdef DMEM_ARB_RR_EN
    .last_grant (last_grant),
`endif
    .grant_vld  (grant_vld),
    .grant_id   (grant_id)
  );

  assign win_we    = grant_id ? r1_we    : r0_we;
  assign win_addr  = grant_id ? r1_addr  : r0_addr;
  assign win_wdata = grant_id ? r1_wdata : r0_wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Memory strobes are combinational from state so an async reset kills them immediately.
  always_comb begin
    state_nxt       = state;
    mem_access_addr = '0;
    mem_write_data  = '0;
    mem_write_en    = 1'b0;
    mem_read        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant_vld) begin
          state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        state_nxt       = ST_RESP;
        mem_access_addr = lat_addr;
        mem_write_data  = lat_wdata;
        mem_write_en    = lat_we & ~lat_bad;
        mem_read        = ~lat_we & ~lat_bad;
      end
      ST_RESP: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_id    <= REQ_CPU;
      lat_we    <= 1'b0;
      lat_bad   <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      r0_done   <= 1'b0;
      r0_err    <= 1'b0;
      r0_rdata  <= '0;
      r1_done   <= 1'b0;
      r1_err    <= 1'b0;
      r1_rdata  <= '0;
`ifdef DMEM_ARB_RR_EN
      last_grant <= REQ_DMA;
`endif
    end else begin
      r0_done <= 1'b0;
      r0_err  <= 1'b0;
      r1_done <= 1'b0;
      r1_err  <= 1'b0;
      if (state == ST_IDLE && grant_vld) begin
        lat_id    <= grant_id;
        lat_we    <= win_we;
        lat_addr  <= win_addr;
        lat_wdata <= win_wdata;
        lat_bad   <= !addr_ok(win_addr, MEM_WORDS);
`ifdef DMEM_ARB_RR_EN
        last_grant <= grant_id;
`endif
      end
      // Completion registers load on the ACCESS->RESP edge, so they are visible during RESP.
      if (state == ST_ACCESS) begin
        if (lat_id == REQ_CPU) begin
          r0_done <= 1'b1;
          r0_err  <= lat_bad;
          if (lat_bad) begin
            r0_rdata <= '0;
          end else if (!lat_we) begin
            r0_rdata <= mem_read_data;
          end
        end else begin
          r1_done <= 1'b1;
          r1_err  <= lat_bad;
          if (lat_bad) begin
            r1_rdata <= '0;
          end else if (!lat_we) begin
            r1_rdata <= mem_read_data;
          end
        end
      end
    end
  end

endmodule
